// File: rtl/word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
// Read-domain consumer of the CDC buffer wrapper. Collects DATA_W-bit words
// arriving as single-cycle strobes and packs WORDS of them into one wide word.
// The packed word is offered downstream over a valid/ready handshake. The input
// side cannot be stalled, so a group that completes while the output register
// is blocked is dropped and flagged on a sticky overflow.
//
// Ports
//   clk         read-domain clock, rising edge
//   rst         asynchronous reset, active-low
//   in_valid    word strobe (wrapper data_2_valid)
//   in_data     input word (wrapper data_2)
//   flush       emit the partial group now
//   pack_ready  downstream accepts pack_data
//   pack_valid  pack_data/pack_len hold a packed word
//   pack_data   packed word, word 0 in bits [DATA_W-1:0]
//   pack_len    number of valid words in pack_data (1..WORDS)
//   fill_count  words currently held in the accumulator
//   overflow    sticky: a completed group was dropped
// -----------------------------------------------------------------------------
module word_packer #(
   parameter int DATA_W = 16,
   parameter int WORDS  = 4,
   parameter int LEN_W  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    flush,
   input  logic                    pack_ready,
   output logic                    pack_valid,
   output logic [DATA_W*WORDS-1:0] pack_data,
   output logic [LEN_W-1:0]        pack_len,
   output logic [LEN_W-1:0]        fill_count,
   output logic                    overflow
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                         state_q;
   logic [WORDS-1:0][DATA_W-1:0]   acc_q;
   logic [WORDS-1:0][DATA_W-1:0]   acc_d;
   logic [LEN_W-1:0]               fill_q;
   logic [LEN_W-1:0]               cnt_d;
   logic [DATA_W*WORDS-1:0]        pack_data_q;
   logic [LEN_W-1:0]               pack_len_q;
   logic                           overflow_q;
   logic                           complete;
   logic                           blocked;

   // Accumulator contents and word count as they stand once this edge's word
   // (if any) is included. Slices above the count are always zero because the
   // accumulator is cleared on every completion and filled strictly in order.
   always_comb begin
      acc_d = acc_q;
      for (int k = 0; k < WORDS; k++) begin
         if (in_valid && (fill_q == LEN_W'(k))) begin
            acc_d[k] = in_data;
         end
      end
      cnt_d    = fill_q + {{(LEN_W-1){1'b0}}, in_valid};
      // A word filling the last slice completes the group even if flush is
      // also high; flush alone completes only a non-empty group.
      complete = (in_valid && (fill_q == LEN_W'(WORDS-1))) ||
                 (flush && (cnt_d != '0));
      blocked  = (state_q == FULL) && !pack_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= EMPTY;
         acc_q       <= '0;
         fill_q      <= '0;
         pack_data_q <= '0;
         pack_len_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         if (complete) begin
            fill_q <= '0;
            acc_q  <= '0;
            if (blocked) begin
               // Output still holds an unaccepted word: drop the new group.
               overflow_q <= 1'b1;
            end else begin
               // Covers both EMPTY->FULL and a back-to-back FULL reload.
               state_q     <= FULL;
               pack_data_q <= acc_d;
               pack_len_q  <= cnt_d;
            end
         end else begin
            fill_q <= cnt_d;
            acc_q  <= acc_d;
            if ((state_q == FULL) && pack_ready) begin
               state_q <= EMPTY;
            end
         end
      end
   end

   assign pack_valid = (state_q == FULL);
   assign pack_data  = pack_data_q;
   assign pack_len   = pack_len_q;
   assign fill_count = fill_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_word_packer.sv
module tb_word_packer;

   localparam int DATA_W = 16;
   localparam int WORDS  = 4;
   localparam int LEN_W  = 3;
   localparam int PW     = DATA_W * WORDS;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              flush = 1'b0;
   logic              pack_ready = 1'b0;
   logic              pack_valid;
   logic [PW-1:0]     pack_data;
   logic [LEN_W-1:0]  pack_len;
   logic [LEN_W-1:0]  fill_count;
   logic              overflow;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   logic [DATA_W-1:0] m_words[$];
   logic [PW-1:0]     exp_data_q[$];
   logic [LEN_W-1:0]  exp_len_q[$];
   bit                m_valid = 1'b0;
   bit                m_ovf   = 1'b0;

   word_packer #(.DATA_W(DATA_W), .WORDS(WORDS), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .flush      (flush),
      .pack_ready (pack_ready),
      .pack_valid (pack_valid),
      .pack_data  (pack_data),
      .pack_len   (pack_len),
      .fill_count (fill_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Advance the model by the edge that will sample these inputs.
   task automatic model_edge(input bit v, input logic [DATA_W-1:0] d, input bit f, input bit r);
      bit            comp;
      logic [PW-1:0] pk;
      comp = 1'b0;
      if (v) m_words.push_back(d);
      if (m_words.size() == WORDS) comp = 1'b1;
      else if (f && (m_words.size() > 0)) comp = 1'b1;
      if (comp) begin
         if (m_valid && !r) begin
            m_ovf = 1'b1;
         end else begin
            pk = '0;
            foreach (m_words[i]) pk[i*DATA_W +: DATA_W] = m_words[i];
            exp_data_q.push_back(pk);
            exp_len_q.push_back(LEN_W'(m_words.size()));
            m_valid = 1'b1;
         end
         m_words.delete();
      end else if (m_valid && r) begin
         m_valid = 1'b0;
      end
   endtask

   // Called at posedge+1; returns at the following posedge+1.
   task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input bit f, input bit r);
      in_valid   = v;
      in_data    = d;
      flush      = f;
      pack_ready = r;
      model_edge(v, d, f, r);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      #2 rst = 1'b0;
      m_words.delete();
      exp_data_q.delete();
      exp_len_q.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      #1;
      chk({tag, "_valid"}, pack_valid, 0);
      chk({tag, "_data"},  pack_data,  0);
      chk({tag, "_len"},   pack_len,   0);
      chk({tag, "_fill"},  fill_count, 0);
      chk({tag, "_ovf"},   overflow,   0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: compare each transfer against the oldest expected word.
   always @(negedge clk) begin
      if (rst && pack_valid && pack_ready) begin
         if (exp_data_q.size() == 0) begin
            chk("unexpected_pack", pack_data, 0);
         end else begin
            chk("pack_data", pack_data, exp_data_q.pop_front());
            chk("pack_len",  pack_len,  exp_len_q.pop_front());
         end
      end
   end

   initial begin
      #3;
      chk("por_valid", pack_valid, 0);
      chk("por_fill",  fill_count, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 1. reset mid-group
      cyc(1, 16'h0001, 0, 1);
      cyc(1, 16'h0002, 0, 1);
      chk("t1_fill2", fill_count, 2);
      do_reset("t1_rst");

      // 2. normal pack (also proves nothing stale survived the reset)
      for (int i = 1; i <= 4; i++) cyc(1, 16'(i), 0, 1);
      chk("t2_valid", pack_valid, 1);
      chk("t2_data",  pack_data,  64'h0004_0003_0002_0001);
      chk("t2_len",   pack_len,   4);
      chk("t2_fill",  fill_count, 0);
      cyc(0, 0, 0, 1);
      chk("t2_taken", pack_valid, 0);

      // 3. backpressure and overflow
      for (int i = 1; i <= 4; i++) cyc(1, 16'(i), 0, 0);
      chk("t3_valid", pack_valid, 1);
      for (int i = 5; i <= 8; i++) cyc(1, 16'(i), 0, 0);
      chk("t3_ovf",   overflow,   1);
      chk("t3_hold",  pack_data,  64'h0004_0003_0002_0001);
      chk("t3_len",   pack_len,   4);
      chk("t3_fill",  fill_count, 0);
      cyc(0, 0, 0, 1);
      chk("t3_taken", pack_valid, 0);
      chk("t3_ovf_sticky", overflow, 1);
      do_reset("t3_rst");

      // 4. back-to-back
      for (int i = 'h11; i <= 'h18; i++) cyc(1, 16'(i), 0, 1);
      cyc(0, 0, 0, 1);
      chk("t4_valid",   pack_valid, 0);
      chk("t4_ovf",     overflow,   0);
      chk("t4_drained", exp_data_q.size(), 0);

      // 5. flush
      cyc(1, 16'h00AA, 0, 1);
      cyc(1, 16'h00BB, 0, 1);
      cyc(0, 0, 1, 0);
      chk("t5_valid", pack_valid, 1);
      chk("t5_data",  pack_data,  64'h0000_0000_00BB_00AA);
      chk("t5_len",   pack_len,   2);
      cyc(0, 0, 1, 1);
      chk("t5_empty_flush", pack_valid, 0);
      chk("t5_fill",  fill_count, 0);

      // 6. flush together with the filling word
      for (int i = 1; i <= 3; i++) cyc(1, 16'(i), 0, 1);
      cyc(1, 16'h0004, 1, 1);
      chk("t6_len",  pack_len,   4);
      chk("t6_data", pack_data,  64'h0004_0003_0002_0001);
      chk("t6_fill", fill_count, 0);
      cyc(0, 0, 0, 1);

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         cyc(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) != 0));
         chk("rnd_fill", fill_count, m_words.size());
      end
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
      chk("rnd_drained", exp_data_q.size(), 0);
      chk("rnd_ovf",     overflow, m_ovf);
      chk("rnd_valid",   pack_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
